// File: rtl/operand2_pkg.sv
// operand2_pkg: shift/mode constants and the S1->S2 request record shared by operand2_shifter (OPERAND2_REG_SHIFT_EN selects the Rs path)
package operand2_pkg;
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;
  localparam logic [1:0] MODE_MEM = 2'd0;
  localparam logic [1:0] MODE_IMM = 2'd1;
  localparam logic [1:0] MODE_SHIFT = 2'd2;
  localparam int AMT_MAX_W = 8;
  typedef enum logic [1:0] {CSEL_CORE, CSEL_LSB, CSEL_MSB, CSEL_ZERO} carry_sel_t;
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] shift_type;
    logic [AMT_MAX_W-1:0] amount;
    logic rrx;
    logic zero_result;
    logic sign_fill;
    carry_sel_t carry_sel;
  } req_t;
endpackage

// File: rtl/operand2_shifter_if.sv
// operand2_shifter_if: request/response bus of operand2_shifter (val_rs/reg_shift only matter with OPERAND2_REG_SHIFT_EN)
interface operand2_shifter_if #(parameter int DATA_W = 32);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val_rs;
  logic imm;
  logic reg_shift;
  logic [11:0] shift_operand;
  logic mem_r_en;
  logic mem_w_en;
  logic carry_in;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] val2;
  logic carry_out;
  modport master (
    output flush, in_valid, val_rm, val_rs, imm, reg_shift, shift_operand, mem_r_en, mem_w_en, carry_in, out_ready,
    input in_ready, out_valid, val2, carry_out
  );
  modport slave (
    input flush, in_valid, val_rm, val_rs, imm, reg_shift, shift_operand, mem_r_en, mem_w_en, carry_in, out_ready,
    output in_ready, out_valid, val2, carry_out
  );
endinterface

// File: rtl/operand2_shifter_core.sv
// barrel_shift_core: combinational LSL/LSR/ASR/ROR by 0..DATA_W-1 with shifter carry-out
module barrel_shift_core
  import operand2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W = $clog2(DATA_W) + 1
) (
  input logic [DATA_W-1:0] value,
  input logic [1:0] shift_type,
  input logic [AMT_W-1:0] amount,
  input logic carry_in,
  output logic [DATA_W-1:0] result,
  output logic carry
);
  logic [AMT_W-2:0] a;
  logic [DATA_W:0] up, dn, sdn;
  logic [DATA_W-1:0] rot;
  logic unused_amt_msb;
  assign a = amount[AMT_W-2:0];
  assign unused_amt_msb = amount[AMT_W-1];
  assign up = {1'b0, value} << a;
  assign dn = {value, 1'b0} >> a;
  assign sdn = $signed({value, 1'b0}) >>> a;
  assign rot = (value >> a) | (value << (AMT_W'(DATA_W) - {1'b0, a}));
  always_comb begin
    result = shift_type == SHIFT_LSL ? up[DATA_W-1:0] :
             shift_type == SHIFT_LSR ? dn[DATA_W:1] :
             shift_type == SHIFT_ASR ? sdn[DATA_W:1] : rot;
    carry = a == '0 ? carry_in :
            shift_type == SHIFT_LSL ? up[DATA_W] :
            shift_type == SHIFT_ROR ? rot[DATA_W-1] : dn[0];
  end
endmodule

// File: rtl/operand2_shifter.sv
// operand2_shifter: two-stage ARM operand-2 unit with valid/ready and flush; OPERAND2_REG_SHIFT_EN enables Rs-specified shifts
module operand2_shifter
  import operand2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W = $clog2(DATA_W) + 1
) (
  input logic clk,
  input logic rst,
  operand2_shifter_if.slave bus
);
  localparam logic [8:0] DW = 9'(DATA_W);
  req_t req_d, s1_req;
  logic [DATA_W-1:0] val_d, s1_val, core_res, res_d;
  logic s1_valid, s1_cin, core_c, carry_d, s2_open, is_reg, big, over, wrap;
  logic [7:0] n;
  logic [1:0] st;
  logic unused_bits;
  assign s2_open = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_open;
  assign st = bus.shift_operand[6:5];
`ifdef OPERAND2_REG_SHIFT_EN
  assign is_reg = bus.reg_shift;
  assign n = is_reg ? bus.val_rs[7:0] : {3'b000, bus.shift_operand[11:7]};
  assign unused_bits = ^{s1_req, bus.val_rs[DATA_W-1:8]};
`else
  assign is_reg = 1'b0;
  assign n = {3'b000, bus.shift_operand[11:7]};
  assign unused_bits = ^{s1_req, bus.val_rs, bus.reg_shift};
`endif
  assign big = {1'b0, n} >= DW;
  assign over = {1'b0, n} > DW;
  assign wrap = n[AMT_W-2:0] == '0;
  always_comb begin
    req_d = '0;
    val_d = bus.val_rm;
    if (bus.mem_r_en || bus.mem_w_en) begin
      req_d.mode = MODE_MEM;
      val_d = DATA_W'(bus.shift_operand);
    end else if (bus.imm) begin
      req_d.mode = MODE_IMM;
      req_d.shift_type = SHIFT_ROR;
      req_d.amount = 8'({bus.shift_operand[11:8], 1'b0} & 5'(DATA_W - 1));
      val_d = DATA_W'(bus.shift_operand[7:0]);
    end else if (n == 8'd0) begin
      req_d.mode = MODE_SHIFT;
      req_d.shift_type = st;
      req_d.rrx = !is_reg && st == SHIFT_ROR;
      req_d.zero_result = !is_reg && st == SHIFT_LSR;
      req_d.sign_fill = !is_reg && st == SHIFT_ASR;
      req_d.carry_sel = is_reg || st == SHIFT_LSL ? CSEL_CORE : st == SHIFT_ROR ? CSEL_LSB : CSEL_MSB;
    end else begin
      req_d.mode = MODE_SHIFT;
      req_d.shift_type = st;
      req_d.amount = 8'(n[AMT_W-2:0]);
      req_d.zero_result = !st[1] && big;
      req_d.sign_fill = st == SHIFT_ASR && big;
      req_d.carry_sel = over && !st[1] ? CSEL_ZERO :
                        big && st == SHIFT_LSL ? CSEL_LSB :
                        (big && st != SHIFT_ROR) || (wrap && st == SHIFT_ROR) ? CSEL_MSB : CSEL_CORE;
    end
  end
  barrel_shift_core #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_core (
    .value(s1_val),
    .shift_type(s1_req.shift_type),
    .amount(s1_req.amount[AMT_W-1:0]),
    .carry_in(s1_cin),
    .result(core_res),
    .carry(core_c)
  );
  assign res_d = s1_req.rrx ? {s1_cin, s1_val[DATA_W-1:1]} :
                 s1_req.zero_result ? '0 :
                 s1_req.sign_fill ? {DATA_W{s1_val[DATA_W-1]}} : core_res;
  assign carry_d = s1_req.carry_sel == CSEL_LSB ? s1_val[0] :
                   s1_req.carry_sel == CSEL_MSB ? s1_val[DATA_W-1] :
                   s1_req.carry_sel == CSEL_ZERO ? 1'b0 : core_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_req <= '0;
      s1_val <= '0;
      s1_cin <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.val2 <= '0;
      bus.carry_out <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      if (s2_open) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.val2 <= res_d;
          bus.carry_out <= carry_d;
        end
      end
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_req <= req_d;
          s1_val <= val_d;
          s1_cin <= bus.carry_in;
        end
      end
    end
  end
endmodule

// File: tb/tb_operand2_shifter.sv
// tb_operand2_shifter: directed vectors scored by a queue-based monitor for operand2_shifter (OPERAND2_REG_SHIFT_EN adds Rs vectors)
module tb_operand2_shifter;
  typedef struct {
    string name;
    logic [31:0] v;
    logic c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  operand2_shifter_if #(.DATA_W(32)) bus ();
  operand2_shifter #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] mem, input logic i, input logic r, input logic [11:0] so,
                       input logic [31:0] rm, input logic [31:0] rs, input logic ci);
    bus.mem_r_en = mem[0];
    bus.mem_w_en = mem[1];
    bus.imm = i;
    bus.reg_shift = r;
    bus.shift_operand = so;
    bus.val_rm = rm;
    bus.val_rs = rs;
    bus.carry_in = ci;
    bus.in_valid = 1'b1;
  endtask
  task automatic issue(input string name, input logic [1:0] mem, input logic i, input logic r, input logic [11:0] so,
                       input logic [31:0] rm, input logic [31:0] rs, input logic ci, input logic [31:0] ev, input logic ec);
    bit done = 0;
    @(negedge clk);
    drive(mem, i, r, so, rm, rs, ci);
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (bus.in_ready) begin
        exp_q.push_back('{name, ev, ec});
        done = 1;
        @(posedge clk);
      end else
        @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: request never accepted", name);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    #2;
    check("drain_pending", exp_q.size(), 0);
  endtask
  always begin
    @(negedge clk);
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: val2 0x%08h carry %0b with nothing pending", bus.val2, bus.carry_out);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("%s val2", mon_e.name), bus.val2, mon_e.v);
        check($sformatf("%s carry", mon_e.name), b(bus.carry_out), b(mon_e.c));
      end
    end
  end
  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", b(bus.out_valid), 0);
    check("reset val2", bus.val2, 0);
    check("reset carry_out", b(bus.carry_out), 0);
    check("reset in_ready", b(bus.in_ready), 1);
    issue("imm_rot4", 2'b00, 1'b1, 1'b0, 12'h4FF, 32'h0, 32'h0, 1'b0, 32'hFF000000, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("latency cycle1 out_valid", b(bus.out_valid), 0);
    @(negedge clk);
    #1;
    check("latency cycle2 out_valid", b(bus.out_valid), 1);
    drain();
    issue("rrx", 2'b00, 1'b0, 1'b0, 12'h060, 32'h00000003, 32'h0, 1'b1, 32'h80000001, 1'b1);
    issue("load", 2'b01, 1'b0, 1'b0, 12'h804, 32'hDEADBEEF, 32'h0, 1'b1, 32'h00000804, 1'b1);
    issue("store_over_imm", 2'b10, 1'b1, 1'b0, 12'h3FF, 32'hDEADBEEF, 32'h0, 1'b0, 32'h000003FF, 1'b0);
    issue("lsl0", 2'b00, 1'b0, 1'b0, 12'h000, 32'h12345678, 32'h0, 1'b1, 32'h12345678, 1'b1);
    issue("lsr32", 2'b00, 1'b0, 1'b0, 12'h020, 32'h80000000, 32'h0, 1'b0, 32'h00000000, 1'b1);
    issue("asr32", 2'b00, 1'b0, 1'b0, 12'h040, 32'h80000000, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    issue("lsl4", 2'b00, 1'b0, 1'b0, 12'h200, 32'hF0000001, 32'h0, 1'b0, 32'h00000010, 1'b1);
    issue("lsr1", 2'b00, 1'b0, 1'b0, 12'h0A0, 32'h00000003, 32'h0, 1'b0, 32'h00000001, 1'b1);
    issue("asr4", 2'b00, 1'b0, 1'b0, 12'h240, 32'h80000008, 32'h0, 1'b0, 32'hF8000000, 1'b1);
    issue("ror8", 2'b00, 1'b0, 1'b0, 12'h460, 32'h12345678, 32'h0, 1'b1, 32'h78123456, 1'b0);
    issue("imm_rot0", 2'b00, 1'b1, 1'b0, 12'h0AB, 32'h0, 32'h0, 1'b1, 32'h000000AB, 1'b1);
    issue("imm_rot1", 2'b00, 1'b1, 1'b0, 12'h1FF, 32'h0, 32'h0, 1'b0, 32'hC000003F, 1'b1);
`ifdef OPERAND2_REG_SHIFT_EN
    issue("reg_lsl32", 2'b00, 1'b0, 1'b1, 12'h010, 32'h80000001, 32'd32, 1'b0, 32'h0, 1'b1);
    issue("reg_lsl33", 2'b00, 1'b0, 1'b1, 12'h010, 32'h80000001, 32'd33, 1'b1, 32'h0, 1'b0);
    issue("reg_asr40", 2'b00, 1'b0, 1'b1, 12'h050, 32'h80000001, 32'd40, 1'b0, 32'hFFFFFFFF, 1'b1);
    issue("reg_lsr0", 2'b00, 1'b0, 1'b1, 12'h030, 32'h80000001, 32'd0, 1'b1, 32'h80000001, 1'b1);
    issue("reg_ror32", 2'b00, 1'b0, 1'b1, 12'h070, 32'h80000001, 32'd32, 1'b0, 32'h80000001, 1'b1);
    issue("reg_lsr32", 2'b00, 1'b0, 1'b1, 12'h030, 32'h80000001, 32'd32, 1'b0, 32'h0, 1'b1);
    issue("reg_lsl4", 2'b00, 1'b0, 1'b1, 12'h010, 32'h80000001, 32'h00000104, 1'b1, 32'h00000010, 1'b0);
    issue("reg_ror36", 2'b00, 1'b0, 1'b1, 12'h070, 32'h80000001, 32'd36, 1'b1, 32'h18000000, 1'b0);
`else
    issue("reg_ignored", 2'b00, 1'b0, 1'b1, 12'h000, 32'h12345678, 32'd5, 1'b0, 32'h12345678, 1'b0);
`endif
    idle();
    drain();
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue("bp_a", 2'b00, 1'b1, 1'b0, 12'h4FF, 32'h0, 32'h0, 1'b0, 32'hFF000000, 1'b1);
    issue("bp_b", 2'b00, 1'b0, 1'b0, 12'h060, 32'h00000003, 32'h0, 1'b1, 32'h80000001, 1'b1);
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b0, 12'h804, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp in_ready", b(bus.in_ready), 0);
      check("bp out_valid", b(bus.out_valid), 1);
      check("bp val2 stable", bus.val2, 32'hFF000000);
      check("bp carry stable", b(bus.carry_out), 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    issue("bp_c", 2'b01, 1'b0, 1'b0, 12'h804, 32'h0, 32'h0, 1'b0, 32'h00000804, 1'b0);
    idle();
    drain();
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue("fl_d", 2'b00, 1'b0, 1'b0, 12'h200, 32'hF0000001, 32'h0, 1'b0, 32'h00000010, 1'b1);
    issue("fl_e", 2'b00, 1'b0, 1'b0, 12'h0A0, 32'h00000003, 32'h0, 1'b0, 32'h00000001, 1'b1);
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b0, 12'h0AB, 32'h0, 32'h0, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("flush out_valid", b(bus.out_valid), 0);
    check("flush in_ready", b(bus.in_ready), 1);
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("flush no_output", b(bus.out_valid), 0);
    end
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b0, 12'h0AB, 32'h0, 32'h0, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("flush_in drop", b(bus.out_valid), 0);
    end
    issue("rst_y", 2'b00, 1'b0, 1'b0, 12'h460, 32'h12345678, 32'h0, 1'b1, 32'h78123456, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid val2", bus.val2, 0);
    for (int k = 0; k < 3; k++) begin
      check("rst_mid out_valid", b(bus.out_valid), 0);
      @(negedge clk);
      #1;
    end
    issue("recover", 2'b00, 1'b0, 1'b0, 12'h240, 32'h80000008, 32'h0, 1'b0, 32'hF8000000, 1'b1);
    idle();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand2_shifter.md
# operand2_shifter

Pipelined, parametrised ARM operand-2 unit for the EX stage. Builds the second ALU/address operand from an immediate, an immediate-shifted register, or a register-shifted register, and produces the shifter carry-out. Full ARM edge cases are covered: RRX, shift-by-32/over-32, and C-flag pass-through. A two-stage valid/ready pipeline with flush lets EX stall or squash without losing or duplicating operands.

## Interface
Parameters:
- DATA_W, 32, operand width; power of two, ≥16
- AMT_W, $clog2(DATA_W)+1, internal shift-amount width (holds 0..DATA_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash both stages at next edge
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept this cycle
- val_rm  in  DATA_W  Rm value
- val_rs  in  DATA_W  Rs value (register-specified shift amount)
- imm  in  1  I bit: rotated 8-bit immediate
- reg_shift  in  1  shift amount from Rs[7:0] instead of shift_operand[11:7]
- shift_operand  in  12  instruction bits [11:0]
- mem_r_en, mem_w_en  in  1 each  load/store command
- carry_in  in  1  current C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- val2  out  DATA_W  operand 2
- carry_out  out  1  shifter carry-out

## Operation
- Priority: load/store > imm > register shift. type = shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Load/store: val2 = zero-extended shift_operand[11:0]; carry_out = carry_in.
- Immediate: val2 = {0, shift_operand[7:0]} rotated right by 2·shift_operand[11:8] mod DATA_W. carry_out = carry_in if rotation is 0, else val2[DATA_W-1].
- Immediate shift, n = shift_operand[11:7]:
  - LSL#0: val2 = rm, carry = carry_in.
  - LSR#0 means LSR#32: val2 = 0, carry = rm[MSB].
  - ASR#0 means ASR#32: val2 = all rm[MSB], carry = rm[MSB].
  - ROR#0 means RRX: val2 = {carry_in, rm[MSB:1]}, carry = rm[0].
  - Otherwise normal shift; carry = last bit shifted out.
- Register shift, n = val_rs[7:0]:
  - n = 0: val2 = rm, carry = carry_in.
  - LSL/LSR with n = DATA_W: val2 = 0, carry = rm[0] (LSL) or rm[MSB] (LSR).
  - LSL/LSR with n > DATA_W: val2 = 0, carry = 0.
  - ASR with n ≥ DATA_W: sign fill, carry = rm[MSB].
  - ROR: rotate by n mod DATA_W. If that is 0 with n ≠ 0: val2 = rm, carry = rm[MSB].
- Stage 1 (S1) registers the operands, resolves mode, type, effective amount (saturated to AMT_W) and the special-case flags. Stage 2 (S2) performs the barrel shift and carry selection, and registers val2/carry_out.

## Timing
- Reset: out_valid = 0, val2 = 0, carry_out = 0, S1 valid = 0. in_ready = 1 in the first cycle after reset.
- Latency: a request accepted at edge k (in_valid && in_ready) is presented with out_valid = 1 after edge k+2, absent stall. Throughput is 1 per cycle.
- in_ready = !s1_valid || !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- While out_valid && !out_ready, val2/carry_out stay stable. S1 holds if S2 is blocked.
- flush: both valid bits clear at the next edge. A request presented in the flush cycle is discarded. flush overrides out_ready and in_valid.
- rst during a transfer clears everything. No partial result is emitted.

## Configuration
- OPERAND2_REG_SHIFT_EN defined: register-specified shift path present as above.
- Not defined: reg_shift and val_rs are ignored. The Rs amount mux and the >DATA_W saturation logic are removed, and every non-immediate, non-memory request is an immediate shift. Latency and handshake are unchanged.

## Structure
- Shared package operand2_pkg holds:
  - shift type constants SHIFT_LSL/LSR/ASR/ROR (2-bit)
  - mode constants MODE_MEM/IMM/SHIFT
  - the S1→S2 request struct: mode, type, amount, rrx, zero_result, sign_fill, carry_sel
- Sub-module barrel_shift_core: combinational, DATA_W-parametrised. Inputs: value, type, amount, carry_in. Outputs: result, carry. Instantiated once, in S2.

## Test plan
- Imm: shift_operand=0x4FF (rot 4 → 8 bits), carry_in=0 → val2=0xFF000000, carry_out=1, out_valid 2 cycles after accept.
- Imm shift RRX: rm=0x00000003, shift_operand=0x060, carry_in=1 → val2=0x80000001, carry_out=1.
- Reg shift (EN): rm=0x80000001, rs=32, LSL → val2=0, carry=1; rs=33 → val2=0, carry=0; ASR rs=40 → 0xFFFFFFFF, carry=1.
- Load offset: mem_r_en=1, shift_operand=0x804 → val2=0x00000804, carry_out=carry_in.
- Backpressure: 3 back-to-back requests with out_ready=0 for 4 cycles → in_ready drops after 2 accepted; outputs stable; all 3 results emitted in order once out_ready=1.
- Flush: flush asserted with both stages full plus a new in_valid → out_valid=0 next cycle; no result for any of the 3 requests.
